// File: rtl/rv_skid_pkg.sv
// Shared types and constants for the rv_pipe_skid valid/ready skid buffer.
package rv_skid_pkg;

  localparam int unsigned RV_SKID_DEF_WIDTH = 28;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } skid_state_e;

endpackage

// File: rtl/rv_skid_dffe.sv
// Enable flop with asynchronous active-low reset to zero; holds main and skid entries.
module rv_skid_dffe
  import rv_skid_pkg::*;
#(
  parameter int unsigned WIDTH = RV_SKID_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/rv_pipe_skid.sv
// Two-entry valid/ready skid buffer; in_ready depends on state only.
// Optional saturating stall counter enabled by defining RV_SKID_PERF_EN.
module rv_pipe_skid
  import rv_skid_pkg::*;
#(
  parameter int unsigned WIDTH = RV_SKID_DEF_WIDTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef RV_SKID_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_en, skid_en;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign out_data  = main_q;
  assign skid_d    = in_data;

  // Flush wins over every transfer; data registers are left as-is.
  always_comb begin
    state_d = state_q;
    main_d  = in_data;
    main_en = 1'b0;
    skid_en = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_valid) begin
            main_en = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_valid && out_ready) begin
            main_en = 1'b1;
          end else if (in_valid) begin
            skid_en = 1'b1;
            state_d = FULL;
          end else if (out_ready) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            main_d  = skid_q;
            main_en = 1'b1;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  rv_skid_dffe #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .rst_l (rst_l),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  rv_skid_dffe #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .rst_l (rst_l),
    .en    (skid_en),
    .d     (skid_d),
    .q     (skid_q)
  );

`ifdef RV_SKID_PERF_EN
  logic [CNT_W-1:0] stall_q;

  // Saturates at all-ones; only reset clears it.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_rv_pipe_skid.sv
// Directed self-checking bench for rv_pipe_skid (also covers RV_SKID_PERF_EN builds).
module tb_rv_pipe_skid;

  localparam int unsigned W  = 28;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst_l;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
`ifdef RV_SKID_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] s0;
`endif

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned failed = 0;

  rv_pipe_skid #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef RV_SKID_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_l     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #3;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_data",  {4'b0, out_data},   32'd0);
`ifdef RV_SKID_PERF_EN
    chk("rst_stall", {28'b0, stall_cnt}, 32'd0);
`endif
    step();
    rst_l = 1'b1;
    step();

    // streaming
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_data = W'(i);
      step();
      chk("stream_data",  {4'b0, out_data},   32'(i));
      chk("stream_valid", {31'b0, out_valid}, 32'd1);
      chk("stream_ready", {31'b0, in_ready},  32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain", {31'b0, out_valid}, 32'd0);

    // backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 28'hABCDEF0;
    step();
    chk("bp_one_data", {4'b0, out_data}, 32'h0ABCDEF0);
    in_data = 28'h1234567;
    step();
    chk("bp_full_ready", {31'b0, in_ready},  32'd0);
    chk("bp_full_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_full_data",  {4'b0, out_data},   32'h0ABCDEF0);

    // hold in FULL
`ifdef RV_SKID_PERF_EN
    s0 = stall_cnt;
`endif
    for (int i = 0; i < 5; i++) begin
      in_data = 28'h5550000 + W'(i);
      step();
      chk("hold_data",  {4'b0, out_data},  32'h0ABCDEF0);
      chk("hold_ready", {31'b0, in_ready}, 32'd0);
    end
`ifdef RV_SKID_PERF_EN
    chk("hold_stall", {28'b0, stall_cnt}, {28'b0, s0 + 4'd5});
`endif
    out_ready = 1'b1;
    in_valid  = 1'b0;
    step();
    chk("bp_second_data",  {4'b0, out_data},   32'h01234567);
    chk("bp_second_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_second_ready", {31'b0, in_ready},  32'd1);
    step();
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    // flush in FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 28'h0AAAAAA;
    step();
    in_data = 28'h0BBBBBB;
    step();
    chk("fl_full_ready", {31'b0, in_ready}, 32'd0);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_data   = 28'h0CCCCCC;
    step();
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_ready", {31'b0, in_ready},  32'd1);
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_stays_empty", {31'b0, out_valid}, 32'd0);
    end
    in_valid = 1'b1;
    in_data  = 28'h0DDDDDD;
    step();
    chk("fl_next_data",  {4'b0, out_data},   32'h00DDDDDD);
    chk("fl_next_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
    step();
    chk("fl_next_empty", {31'b0, out_valid}, 32'd0);

`ifdef RV_SKID_PERF_EN
    // saturation
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 28'h0000001;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_stall", {28'b0, stall_cnt}, 32'h0000000F);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("sat_after_flush", {28'b0, stall_cnt}, 32'h0000000F);
`endif

    // asynchronous reset while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 28'h0EEEEEE;
    step();
    in_data = 28'h0FFFFFF;
    step();
    chk("ar_pre_full", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    #2;
    rst_l = 1'b0;
    #1;
    chk("ar_out_valid", {31'b0, out_valid}, 32'd0);
    chk("ar_in_ready",  {31'b0, in_ready},  32'd1);
    chk("ar_out_data",  {4'b0, out_data},   32'd0);
`ifdef RV_SKID_PERF_EN
    chk("ar_stall", {28'b0, stall_cnt}, 32'd0);
`endif
    step();
    rst_l = 1'b1;
    step();
    chk("ar_after_valid", {31'b0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
